// File: rtl/retry_pkg.sv
// Helpers shared by the start and end sides of the retry pair.
// Operands are zero-extended to 32 bits so one function serves every ID width.
package retry_pkg;

    function automatic logic id_parity(input logic [31:0] payload);
        return ^payload;
    endfunction

    function automatic logic [31:0] id_payload(input logic [31:0] id, input int unsigned id_bits);
        logic [31:0] mask;
        mask = (32'd1 << id_bits) - 32'd1;
        return id & mask;
    endfunction

endpackage

// File: rtl/retry_id_counter.sv
// Issue-ID counter: payload increments on each issue.
// When parity is enabled, the MSB carries the even parity of the payload.
module retry_id_counter
    import retry_pkg::*;
#(
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned ParityEn = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inc_i,
    output logic [IdWidth-1:0] id_o,
    output logic [IdWidth-1:0] id_next_o
);
    localparam int unsigned IdBits = IdWidth - ParityEn;

    logic [IdWidth-1:0] id_q, id_d;
    logic [IdBits-1:0]  pay_inc;

    always_comb begin
        pay_inc = IdBits'(id_payload(32'(id_q), IdBits)) + IdBits'(1);
        id_d    = id_q;
        if (inc_i) begin
            id_d = IdWidth'(pay_inc);
            if (ParityEn != 0) begin
                id_d[IdWidth-1] = id_parity(32'(pay_inc));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_o      = id_q;
    assign id_next_o = id_d;

endmodule

// File: rtl/retry_budget_start.sv
// Start side of an in-order retry pair: tags, stores and replays elements.
// Each element has a bounded retry budget; the final attempt is flagged by last_try_o.
module retry_budget_start
    import retry_pkg::*;
#(
    parameter type         DataType   = logic,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned ParityEn   = 1,
    parameter int unsigned MaxRetries = 3,
    parameter int unsigned StatWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  DataType              data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output DataType              data_o,
    output logic [IdWidth-1:0]   id_o,
    output logic                 last_try_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic                 retry_valid_i,
    input  logic [IdWidth-1:0]   retry_id_i,
    output logic                 retry_ready_o,
    input  logic                 retry_lock_i,
    output logic [IdWidth-1:0]   retry_id_feedback_o,
    output logic                 id_parity_err_o,
    output logic [StatWidth-1:0] replay_count_o
);
    localparam int unsigned IdBits = IdWidth - ParityEn;
    localparam int unsigned Slots  = 1 << IdBits;
    localparam int unsigned CntW   = $clog2(MaxRetries + 1);

    DataType               data_mem_q [Slots];
    logic [CntW-1:0]       cnt_mem_q  [Slots];
    logic                  pend_q, lock_q, err_q;
    logic [IdWidth-1:0]    pend_id_q;
    logic [StatWidth-1:0]  replay_cnt_q;

    logic                  issue, retry_acc, retry_par_ok;
    logic [IdBits-1:0]     pend_slot, cur_slot;
    logic [CntW-1:0]       stored_cnt, attempt_cnt;

    retry_id_counter #(
        .IdWidth  (IdWidth),
        .ParityEn (ParityEn)
    ) u_id_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (issue),
        .id_o      (id_o),
        .id_next_o (retry_id_feedback_o)
    );

    assign pend_slot = IdBits'(id_payload(32'(pend_id_q), IdBits));
    assign cur_slot  = IdBits'(id_payload(32'(id_o), IdBits));

    // Replays advance the stored attempt count but never past the budget.
    always_comb begin
        stored_cnt  = cnt_mem_q[pend_slot];
        attempt_cnt = '0;
        if (pend_q) begin
            attempt_cnt = (stored_cnt >= CntW'(MaxRetries)) ? CntW'(MaxRetries)
                                                            : stored_cnt + CntW'(1);
        end
    end

    always_comb begin
        retry_par_ok = 1'b1;
        if (ParityEn != 0) begin
            retry_par_ok = retry_id_i[IdWidth-1] ==
                           id_parity(id_payload(32'(retry_id_i), IdBits));
        end
    end

    assign valid_o         = (valid_i & ~lock_q) | pend_q;
    assign ready_o         = ready_i & ~pend_q & ~lock_q;
    assign data_o          = pend_q ? data_mem_q[pend_slot] : data_i;
    assign last_try_o      = attempt_cnt == CntW'(MaxRetries);
    assign issue           = valid_o & ready_i;
    assign retry_ready_o   = ready_i | ~pend_q;
    assign retry_acc       = retry_valid_i & retry_ready_o;
    assign id_parity_err_o = err_q;
    assign replay_count_o  = replay_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Slots); i++) begin
                data_mem_q[i] <= '0;
                cnt_mem_q[i]  <= '0;
            end
            pend_q       <= 1'b0;
            pend_id_q    <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            replay_cnt_q <= '0;
        end else begin
            lock_q <= retry_lock_i;
            err_q  <= retry_acc & ~retry_par_ok;
            if (issue) begin
                data_mem_q[cur_slot] <= data_o;
                cnt_mem_q[cur_slot]  <= attempt_cnt;
                if (pend_q && (replay_cnt_q != '1)) begin
                    replay_cnt_q <= replay_cnt_q + StatWidth'(1);
                end
            end
            if (retry_acc && retry_par_ok) begin
                pend_q    <= 1'b1;
                pend_id_q <= retry_id_i;
            end else if (ready_i) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retry_budget_start.sv
// Directed and randomized checks of retry_budget_start against a behavioural model.
module tb_retry_budget_start;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned MaxTry    = 3;
    localparam int unsigned StatWidth = 16;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic [7:0]           data_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [7:0]           data_o;
    logic [IdWidth-1:0]   id_o;
    logic                 last_try_o;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    logic                 retry_valid_i = 1'b0;
    logic [IdWidth-1:0]   retry_id_i = '0;
    logic                 retry_ready_o;
    logic                 retry_lock_i = 1'b0;
    logic [IdWidth-1:0]   retry_id_feedback_o;
    logic                 id_parity_err_o;
    logic [StatWidth-1:0] replay_count_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retry_budget_start #(
        .DataType   (logic [7:0]),
        .IdWidth    (IdWidth),
        .ParityEn   (1),
        .MaxRetries (MaxTry),
        .StatWidth  (StatWidth)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .data_i              (data_i),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .data_o              (data_o),
        .id_o                (id_o),
        .last_try_o          (last_try_o),
        .valid_o             (valid_o),
        .ready_i             (ready_i),
        .retry_valid_i       (retry_valid_i),
        .retry_id_i          (retry_id_i),
        .retry_ready_o       (retry_ready_o),
        .retry_lock_i        (retry_lock_i),
        .retry_id_feedback_o (retry_id_feedback_o),
        .id_parity_err_o     (id_parity_err_o),
        .replay_count_o      (replay_count_o)
    );

    // Model: what was issued under each ID payload and how many attempts it has used.
    int         m_n;
    bit         m_pend, m_lock, m_err;
    logic [3:0] m_pend_id;
    int         m_replays;
    logic [7:0] m_data [8];
    int         m_att [8];
    bit         e_valid;
    logic [7:0] e_data;
    int         e_att;

    function automatic logic [3:0] mk_id(input int n);
        logic [2:0] p;
        p = 3'(n % 8);
        return {^p, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_pend = 0; m_lock = 0; m_err = 0; m_pend_id = '0; m_replays = 0;
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_att[i]  = 0;
        end
    endtask

    task automatic model_outputs();
        int slot;
        slot    = int'(m_pend_id[2:0]);
        e_valid = (valid_i && !m_lock) || m_pend;
        e_data  = m_pend ? m_data[slot] : data_i;
        e_att   = 0;
        if (m_pend) e_att = (m_att[slot] + 1 > int'(MaxTry)) ? int'(MaxTry) : m_att[slot] + 1;
    endtask

    task automatic check_cycle();
        bit issue;
        model_outputs();
        issue = e_valid && ready_i;
        chk("valid_o", 32'(valid_o), 32'(e_valid));
        chk("data_o", 32'(data_o), 32'(e_data));
        chk("id_o", 32'(id_o), 32'(mk_id(m_n)));
        chk("last_try_o", 32'(last_try_o), 32'(e_att == int'(MaxTry)));
        chk("ready_o", 32'(ready_o), 32'(ready_i && !m_pend && !m_lock));
        chk("retry_ready_o", 32'(retry_ready_o), 32'(ready_i || !m_pend));
        chk("id_parity_err_o", 32'(id_parity_err_o), 32'(m_err));
        chk("replay_count_o", 32'(replay_count_o), 32'(m_replays));
        chk("retry_id_feedback_o", 32'(retry_id_feedback_o),
            32'(issue ? mk_id(m_n + 1) : mk_id(m_n)));
    endtask

    task automatic tick();
        bit issue, acc, good;
        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            model_outputs();
            issue = e_valid && ready_i;
            acc   = retry_valid_i && (ready_i || !m_pend);
            good  = retry_id_i[3] == ^retry_id_i[2:0];
            if (issue) begin
                m_data[m_n] = e_data;
                m_att[m_n]  = e_att;
                if (m_pend && m_replays < 65535) m_replays++;
                m_n = (m_n + 1) % 8;
            end
            m_err = acc && !good;
            if (acc && good) begin
                m_pend    = 1'b1;
                m_pend_id = retry_id_i;
            end else if (ready_i) begin
                m_pend = 1'b0;
            end
            m_lock = retry_lock_i;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; valid_i = 0; ready_i = 0; retry_valid_i = 0; retry_lock_i = 0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_ids [5];
        exp_ids[0] = 4'h0; exp_ids[1] = 4'h9; exp_ids[2] = 4'hA;
        exp_ids[3] = 4'h3; exp_ids[4] = 4'hC;
        model_reset();
        do_reset();

        // Reset state and the first five IDs.
        #4;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_id_o", 32'(id_o), 32'd0);
        chk("rst_replay_count", 32'(replay_count_o), 32'd0);
        chk("rst_parity_err", 32'(id_parity_err_o), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            valid_i = 1; ready_i = 1; data_i = 8'h10 + 8'(k);
            #4;
            check_cycle();
            chk("t1_id", 32'(id_o), 32'(exp_ids[k]));
            chk("t1_last", 32'(last_try_o), 32'd0);
            tick();
        end

        // Element D5 at ID 9, then replayed under fresh IDs until its budget runs out.
        do_reset();
        valid_i = 1; ready_i = 1; data_i = 8'h00; #4; check_cycle(); tick();
        data_i = 8'hD5; #4; check_cycle(); chk("t2_id9", 32'(id_o), 32'h9); tick();
        valid_i = 0; retry_valid_i = 1; retry_id_i = 4'h9;
        #4; check_cycle(); chk("t2_rr", 32'(retry_ready_o), 32'd1); tick();
        retry_valid_i = 0; valid_i = 1; data_i = 8'h77;
        #4; check_cycle();
        chk("t2_valid", 32'(valid_o), 32'd1);
        chk("t2_data", 32'(data_o), 32'hD5);
        chk("t2_ready_o", 32'(ready_o), 32'd0);
        chk("t2_newid", 32'(id_o), 32'hA);
        chk("t3_last1", 32'(last_try_o), 32'd0);
        tick();
        valid_i = 0; retry_valid_i = 1; retry_id_i = 4'hA;
        #4; check_cycle(); chk("t2_replays", 32'(replay_count_o), 32'd1); tick();
        retry_id_i = 4'h3;
        #4; check_cycle();
        chk("t3_data2", 32'(data_o), 32'hD5);
        chk("t3_last2", 32'(last_try_o), 32'd0);
        tick();
        retry_valid_i = 0;
        #4; check_cycle();
        chk("t3_id3", 32'(id_o), 32'hC);
        chk("t3_last3", 32'(last_try_o), 32'd1);
        tick();
        #4; check_cycle();
        chk("t3_last_after", 32'(last_try_o), 32'd0);
        chk("t3_replays", 32'(replay_count_o), 32'd3);
        tick();

        // Bad-parity retry ID is dropped and flagged one cycle later.
        valid_i = 1; data_i = 8'h42; retry_valid_i = 1; retry_id_i = 4'h1;
        #4; check_cycle(); tick();
        valid_i = 0; retry_valid_i = 0;
        #4; check_cycle();
        chk("t4_err", 32'(id_parity_err_o), 32'd1);
        chk("t4_valid", 32'(valid_o), 32'(valid_i));
        tick();
        #4; check_cycle(); chk("t4_err_clr", 32'(id_parity_err_o), 32'd0); tick();

        // Replay held under backpressure; a second retry waits for ready_i.
        ready_i = 0; valid_i = 1; data_i = 8'h5A; retry_valid_i = 1; retry_id_i = 4'h5;
        #4; check_cycle(); chk("t5_rr_first", 32'(retry_ready_o), 32'd1); tick();
        retry_id_i = 4'h9;
        for (int k = 0; k < 4; k++) begin
            #4; check_cycle();
            chk("t5_rr_held", 32'(retry_ready_o), 32'd0);
            chk("t5_valid_held", 32'(valid_o), 32'd1);
            chk("t5_data_held", 32'(data_o), 32'h42);
            tick();
        end
        ready_i = 1;
        #4; check_cycle(); chk("t5_rr_release", 32'(retry_ready_o), 32'd1); tick();

        // Reset while a replay is pending.
        retry_valid_i = 0; ready_i = 0; rst_i = 1;
        tick();
        rst_i = 0;
        #4; check_cycle();
        chk("t6_valid", 32'(valid_o), 32'd1);
        chk("t6_id", 32'(id_o), 32'd0);
        chk("t6_replays", 32'(replay_count_o), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            valid_i       = ($urandom % 4) != 0;
            data_i        = 8'($urandom);
            ready_i       = ($urandom % 4) != 0;
            retry_valid_i = ($urandom % 4) == 0;
            retry_id_i    = mk_id(int'($urandom % 8));
            if ($urandom % 8 == 0) retry_id_i[3] = ~retry_id_i[3];
            retry_lock_i  = ($urandom % 8) == 0;
            rst_i         = ($urandom % 250) == 0;
            #4; check_cycle();
            tick();
        end
        rst_i = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
